uart_tx_fifo: RTL and testbench

Parametrised UART transmitter with an on-chip transmit FIFO. Data width, stop-bit count and parity mode are configurable. Words queued through a write strobe are serialised LSB-first at a fixed baud rate, and frames go out back-to-back with no idle gap while the FIFO holds data. It replaces the single-word, start-pulse transmitter in the UART path and sits between the host-side data source and the pad driving the serial line.

---
 rtl/uart_tx_fifo_if.sv | 24 ++
 rtl/uart_tx_fifo.sv | 191 +++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// Host-side and line-side signals of the FIFO-buffered UART transmitter.
// The host drives the write side through master; the transmitter implements slave.
interface uart_tx_fifo_if #(
    parameter int p_databits   = 8,
    parameter int p_fifo_depth = 4
);
    logic [p_databits-1:0]         din_i;
    logic                          wr_en_i;
    logic                          full_o;
    logic [$clog2(p_fifo_depth):0] level_o;
    logic                          tx_o;
    logic                          busy_o;
    logic                          tx_done_tick_o;

    modport master (
        output din_i, wr_en_i,
        input  full_o, level_o, tx_o, busy_o, tx_done_tick_o
    );

    modport slave (
        input  din_i, wr_en_i,
        output full_o, level_o, tx_o, busy_o, tx_done_tick_o
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a circular transmit FIFO; frames are sent LSB-first
// and back-to-back while words are queued, with a registered serial output.
module uart_tx_fifo #(
    parameter int p_clkfreq    = 100_000_000,
    parameter int p_baudrate   = 10_000_000,
    parameter int p_databits   = 8,
    parameter int p_stopbit    = 2,
    parameter int p_parity     = 0,
    parameter int p_fifo_depth = 4
) (
    input logic           clk,
    input logic           rst_i,
    uart_tx_fifo_if.slave bus
);

    localparam int c_bittimerlim = p_clkfreq / p_baudrate;
    localparam int c_tw = $clog2(c_bittimerlim);
    localparam int c_cw = $clog2(p_databits + 1);
    localparam int c_pw = $clog2(p_fifo_depth);
    localparam int c_lw = c_pw + 1;

    localparam logic [c_tw-1:0] c_timer_last = c_tw'(c_bittimerlim - 1);
    localparam logic [c_cw-1:0] c_data_last  = c_cw'(p_databits - 1);
    localparam logic [c_cw-1:0] c_stop_last  = c_cw'(p_stopbit - 1);
    localparam logic [c_lw-1:0] c_depth      = c_lw'(p_fifo_depth);
    localparam logic            c_odd        = (p_parity == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic [p_databits-1:0] mem [p_fifo_depth];
    logic [c_pw-1:0]       rd_ptr, wr_ptr;
    logic [c_lw-1:0]       count;
    logic                  pop, push, empty;
    logic [p_databits-1:0] head;

    state_t                state, state_next;
    logic [c_tw-1:0]       bit_timer, timer_next;
    logic [c_cw-1:0]       bit_cnt, cnt_next;
    logic [p_databits-1:0] shreg, shreg_next;
    logic                  parity_bit, parity_next;
    logic                  tx, tx_next;
    logic                  done_tick;
    logic                  tick;

    assign empty       = (count == '0);
    assign head        = mem[rd_ptr];
    assign bus.full_o  = (count == c_depth);
    assign bus.level_o = count;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push        = bus.wr_en_i && (!bus.full_o || pop);
    assign tick        = (bit_timer == c_timer_last);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.din_i;
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state      <= S_IDLE;
            bit_timer  <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            parity_bit <= 1'b0;
            tx         <= 1'b1;
        end else begin
            state      <= state_next;
            bit_timer  <= timer_next;
            bit_cnt    <= cnt_next;
            shreg      <= shreg_next;
            parity_bit <= parity_next;
            tx         <= tx_next;
        end
    end

    always_comb begin
        state_next  = state;
        timer_next  = bit_timer;
        cnt_next    = bit_cnt;
        shreg_next  = shreg;
        parity_next = parity_bit;
        pop         = 1'b0;
        done_tick   = 1'b0;

        case (state)
            S_IDLE: begin
                timer_next = '0;
                cnt_next   = '0;
                if (!empty) begin
                    pop         = 1'b1;
                    shreg_next  = head;
                    parity_next = (^head) ^ c_odd;
                    state_next  = S_START;
                end
            end
            S_START: begin
                if (tick) begin
                    timer_next = '0;
                    state_next = S_DATA;
                end else begin
                    timer_next = bit_timer + 1'b1;
                end
            end
            S_DATA: begin
                if (tick) begin
                    timer_next = '0;
                    shreg_next = shreg >> 1;
                    if (bit_cnt == c_data_last) begin
                        cnt_next   = '0;
                        state_next = (p_parity != 0) ? S_PARITY : S_STOP;
                    end else begin
                        cnt_next = bit_cnt + 1'b1;
                    end
                end else begin
                    timer_next = bit_timer + 1'b1;
                end
            end
            S_PARITY: begin
                if (tick) begin
                    timer_next = '0;
                    state_next = S_STOP;
                end else begin
                    timer_next = bit_timer + 1'b1;
                end
            end
            S_STOP: begin
                if (tick && bit_cnt == c_stop_last) begin
                    // Chain straight into the next start bit to avoid an idle gap.
                    done_tick  = 1'b1;
                    timer_next = '0;
                    cnt_next   = '0;
                    if (!empty) begin
                        pop         = 1'b1;
                        shreg_next  = head;
                        parity_next = (^head) ^ c_odd;
                        state_next  = S_START;
                    end else begin
                        state_next = S_IDLE;
                    end
                end else if (tick) begin
                    timer_next = '0;
                    cnt_next   = bit_cnt + 1'b1;
                end else begin
                    timer_next = bit_timer + 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // The line level is computed from the next state so tx is a clean flop output.
    always_comb begin
        tx_next = 1'b1;
        case (state_next)
            S_IDLE:   tx_next = 1'b1;
            S_START:  tx_next = 1'b0;
            S_DATA:   tx_next = shreg_next[0];
            S_PARITY: tx_next = parity_next;
            S_STOP:   tx_next = 1'b1;
            default:  tx_next = 1'b1;
        endcase
    end

    assign bus.tx_o           = tx;
    assign bus.busy_o         = (state != S_IDLE);
    assign bus.tx_done_tick_o = done_tick;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: four instances cover default framing, even and
// odd parity, and single stop bit; expected line patterns are written out by hand.
module tb_uart_tx_fifo;

    logic clk;
    logic rst;
    int   compared;
    int   mismatched;
    int   cyc;

    uart_tx_fifo_if #(.p_databits(8), .p_fifo_depth(4)) if_def ();
    uart_tx_fifo_if #(.p_databits(8), .p_fifo_depth(4)) if_even ();
    uart_tx_fifo_if #(.p_databits(8), .p_fifo_depth(4)) if_odd ();
    uart_tx_fifo_if #(.p_databits(8), .p_fifo_depth(4)) if_s1 ();

    uart_tx_fifo u_def (.clk(clk), .rst_i(rst), .bus(if_def));
    uart_tx_fifo #(.p_parity(1)) u_even (.clk(clk), .rst_i(rst), .bus(if_even));
    uart_tx_fifo #(.p_parity(2)) u_odd (.clk(clk), .rst_i(rst), .bus(if_odd));
    uart_tx_fifo #(.p_stopbit(1)) u_s1 (.clk(clk), .rst_i(rst), .bus(if_s1));

    logic tx_w [4];
    logic done_w [4];
    logic busy_w [4];
    logic [2:0] level_w [4];
    logic full_w [4];

    assign tx_w[0] = if_def.tx_o;
    assign tx_w[1] = if_even.tx_o;
    assign tx_w[2] = if_odd.tx_o;
    assign tx_w[3] = if_s1.tx_o;
    assign done_w[0] = if_def.tx_done_tick_o;
    assign done_w[1] = if_even.tx_done_tick_o;
    assign done_w[2] = if_odd.tx_done_tick_o;
    assign done_w[3] = if_s1.tx_done_tick_o;
    assign busy_w[0] = if_def.busy_o;
    assign busy_w[1] = if_even.busy_o;
    assign busy_w[2] = if_odd.busy_o;
    assign busy_w[3] = if_s1.busy_o;
    assign level_w[0] = if_def.level_o;
    assign level_w[1] = if_even.level_o;
    assign level_w[2] = if_odd.level_o;
    assign level_w[3] = if_s1.level_o;
    assign full_w[0] = if_def.full_o;
    assign full_w[1] = if_even.full_o;
    assign full_w[2] = if_odd.full_o;
    assign full_w[3] = if_s1.full_o;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input int sel, input logic [7:0] data, input logic wr);
        case (sel)
            0: begin if_def.din_i = data;  if_def.wr_en_i = wr;  end
            1: begin if_even.din_i = data; if_even.wr_en_i = wr; end
            2: begin if_odd.din_i = data;  if_odd.wr_en_i = wr;  end
            default: begin if_s1.din_i = data; if_s1.wr_en_i = wr; end
        endcase
    endtask

    // Called at the negedge holding the start bit's first cycle; returns one cycle past the frame.
    task automatic checkFrame(input int sel, input int nbits, input logic [31:0] exp_bits,
                              input string tag, output int done_cyc);
        int          bad_cycles;
        int          done_cnt;
        int          done_pos;
        logic [31:0] got;
        bad_cycles = 0;
        done_cnt   = 0;
        done_pos   = -1;
        done_cyc   = -1;
        got        = '0;
        for (int k = 0; k < nbits * 10; k++) begin
            if (tx_w[sel] !== exp_bits[k / 10]) bad_cycles++;
            if (k % 10 == 5) got[k / 10] = tx_w[sel];
            if (done_w[sel] === 1'b1) begin
                done_cnt++;
                done_pos = k;
                done_cyc = cyc;
            end
            @(negedge clk);
        end
        checkOutput({tag, "_word"}, got, exp_bits);
        checkOutput({tag, "_bit_timing"}, bad_cycles, 0);
        checkOutput({tag, "_done_count"}, done_cnt, 1);
        checkOutput({tag, "_done_pos"}, done_pos, nbits * 10 - 1);
    endtask

    initial begin
        int   d1;
        int   d2;
        int   dummy;
        int   bad;
        logic seen;

        compared   = 0;
        mismatched = 0;
        cyc        = 0;
        rst        = 1'b1;
        for (int s = 0; s < 4; s++) applyStimulus(s, 8'h00, 1'b0);

        repeat (3) @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            checkOutput($sformatf("reset_tx%0d", s), tx_w[s], 1'b1);
            checkOutput($sformatf("reset_level%0d", s), level_w[s], 3'd0);
            checkOutput($sformatf("reset_full%0d", s), full_w[s], 1'b0);
        end
        checkOutput("reset_busy", busy_w[0], 1'b0);
        checkOutput("reset_done", done_w[0], 1'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single 0xA5 from idle, default framing
        applyStimulus(0, 8'hA5, 1'b1);
        @(negedge clk);
        applyStimulus(0, 8'h00, 1'b0);
        checkOutput("a5_tx_before_pop", tx_w[0], 1'b1);
        checkOutput("a5_level_queued", level_w[0], 3'd1);
        @(negedge clk);
        checkOutput("a5_busy_start", busy_w[0], 1'b1);
        checkOutput("a5_level_popped", level_w[0], 3'd0);
        checkFrame(0, 11, {21'd0, 2'b11, 8'hA5, 1'b0}, "a5", dummy);
        checkOutput("a5_busy_after", busy_w[0], 1'b0);
        checkOutput("a5_tx_after", tx_w[0], 1'b1);

        // Even and odd parity, 0xA5 has four ones
        applyStimulus(1, 8'hA5, 1'b1);
        @(negedge clk);
        applyStimulus(1, 8'h00, 1'b0);
        @(negedge clk);
        checkFrame(1, 12, {20'd0, 2'b11, 1'b0, 8'hA5, 1'b0}, "even", dummy);
        checkOutput("even_busy_after", busy_w[1], 1'b0);

        applyStimulus(2, 8'hA5, 1'b1);
        @(negedge clk);
        applyStimulus(2, 8'h00, 1'b0);
        @(negedge clk);
        checkFrame(2, 12, {20'd0, 2'b11, 1'b1, 8'hA5, 1'b0}, "odd", dummy);
        checkOutput("odd_busy_after", busy_w[2], 1'b0);

        // One stop bit, 0x00 then 0xFF on consecutive cycles
        applyStimulus(3, 8'h00, 1'b1);
        @(negedge clk);
        applyStimulus(3, 8'hFF, 1'b1);
        @(negedge clk);
        applyStimulus(3, 8'h00, 1'b0);
        checkFrame(3, 10, {22'd0, 1'b1, 8'h00, 1'b0}, "s1_first", d1);
        checkFrame(3, 10, {22'd0, 1'b1, 8'hFF, 1'b0}, "s1_second", d2);
        checkOutput("s1_tick_gap", d2 - d1, 100);
        checkOutput("s1_busy_after", busy_w[3], 1'b0);

        // Six writes into a depth-4 FIFO: 0x06 must be dropped
        repeat (3) @(negedge clk);
        applyStimulus(0, 8'h01, 1'b1);
        fork
            begin
                for (int i = 2; i <= 6; i++) begin
                    @(negedge clk);
                    if (i == 6) begin
                        checkOutput("six_full_at4", full_w[0], 1'b1);
                        checkOutput("six_level_at4", level_w[0], 3'd4);
                    end
                    applyStimulus(0, 8'(i), 1'b1);
                end
                @(negedge clk);
                applyStimulus(0, 8'h00, 1'b0);
                checkOutput("six_full_drop", full_w[0], 1'b1);
                checkOutput("six_level_drop", level_w[0], 3'd4);
            end
            begin
                repeat (2) @(negedge clk);
                for (int f = 1; f <= 5; f++) begin
                    checkFrame(0, 11, {21'd0, 2'b11, 8'(f), 1'b0}, $sformatf("six_f%0d", f), dummy);
                    checkOutput($sformatf("six_level_f%0d", f), level_w[0], 3'(5 - f - (f == 5 ? 0 : 1)));
                end
            end
        join
        checkOutput("six_busy_end", busy_w[0], 1'b0);
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) bad++;
            @(negedge clk);
        end
        checkOutput("six_no_sixth_frame", bad, 0);

        // Full FIFO plus a write on the cycle of an end-of-frame pop
        applyStimulus(0, 8'h11, 1'b1);
        for (int i = 2; i <= 5; i++) begin
            @(negedge clk);
            applyStimulus(0, 8'(8'h10 + i), 1'b1);
        end
        @(negedge clk);
        applyStimulus(0, 8'h00, 1'b0);
        checkOutput("pp_full_before", full_w[0], 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (done_w[0] === 1'b1) seen = 1'b1;
        end
        checkOutput("pp_wait_tick", seen, 1'b1);
        if (seen) begin
            applyStimulus(0, 8'h16, 1'b1);
            @(negedge clk);
            applyStimulus(0, 8'h00, 1'b0);
            checkOutput("pp_level_kept", level_w[0], 3'd4);
            checkOutput("pp_full_kept", full_w[0], 1'b1);
            for (int f = 2; f <= 6; f++) begin
                checkFrame(0, 11, {21'd0, 2'b11, 8'(8'h10 + f), 1'b0}, $sformatf("pp_f%0d", f), dummy);
            end
            checkOutput("pp_level_end", level_w[0], 3'd0);
            checkOutput("pp_busy_end", busy_w[0], 1'b0);
        end

        // Reset 50 cycles into 0x21 with 0x22 and 0x23 queued
        repeat (3) @(negedge clk);
        applyStimulus(0, 8'h21, 1'b1);
        @(negedge clk);
        applyStimulus(0, 8'h22, 1'b1);
        @(negedge clk);
        applyStimulus(0, 8'h23, 1'b1);
        @(negedge clk);
        applyStimulus(0, 8'h00, 1'b0);
        checkOutput("rst_level_queued", level_w[0], 3'd2);
        repeat (49) @(negedge clk);
        checkOutput("rst_tx_low_before", tx_w[0], 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_tx_async", tx_w[0], 1'b1);
        checkOutput("rst_busy_async", busy_w[0], 1'b0);
        checkOutput("rst_level_async", level_w[0], 3'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) bad++;
        end
        checkOutput("rst_no_frames", bad, 0);
        checkOutput("rst_level_after", level_w[0], 3'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
